// File: rtl/reg_file_scan.sv
// -----------------------------------------------------------------------------
// reg_file_scan
//   Two-read / one-write register file with a handshaked scan-out port that
//   walks every register once, in address order, on request.
//
//   Ports
//     clk        : sole clock, rising edge
//     rst        : asynchronous active-low reset
//     we3/wa3/wd3: write port (enable, address, data)
//     ra1/rd1    : read port 1 (combinational, write-through bypass)
//     ra2/rd2    : read port 2 (combinational, write-through bypass)
//     scan_start : request a full-bank scan-out (honoured only when idle)
//     scan_ready : consumer accepts the current scan word
//     scan_valid : scan_addr/scan_data carry a valid word
//     scan_addr  : address of the current scan word
//     scan_data  : contents of the register at scan_addr
//     scan_busy  : scan engine is not idle
//     scan_done  : one-cycle pulse after the last word is accepted
//
//   Scan FSM
//     state  | meaning
//     -------+-------------------------------------------------------------
//     S_IDLE | waiting for scan_start; scan outputs quiet
//     S_SHOW | presenting register idx_q, advancing on valid & ready
//     S_DONE | one-cycle completion pulse, then back to S_IDLE
// -----------------------------------------------------------------------------
module reg_file_scan #(
  parameter int N       = 8,
  parameter int A       = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we3,
  input  logic [A-1:0] wa3,
  input  logic [N-1:0] wd3,
  input  logic [A-1:0] ra1,
  input  logic [A-1:0] ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  input  logic         scan_start,
  input  logic         scan_ready,
  output logic         scan_valid,
  output logic [A-1:0] scan_addr,
  output logic [N-1:0] scan_data,
  output logic         scan_busy,
  output logic         scan_done
);

  localparam int           D        = 1 << A;
  localparam logic [A-1:0] LAST_IDX = A'(D - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [N-1:0] mem_q [D];
  logic [1:0]   state_q, state_d;
  logic [A-1:0] idx_q,   idx_d;
  logic         wr_ok;

  // A write only takes effect (and only bypasses to the read side) when out
  // of reset and not aimed at a hard-wired zero register 0.
  always_comb begin
    wr_ok = rst && we3;
    if ((ZERO_R0 != 0) && (wa3 == '0)) begin
      wr_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wa3] <= wd3;
    end
  end

  // Shared read path for rd1, rd2 and scan_data: register 0 forced to zero
  // when configured, otherwise the in-flight write wins over stored contents.
  function automatic logic [N-1:0] read_port(input logic [A-1:0] addr);
    if ((ZERO_R0 != 0) && (addr == '0)) begin
      return '0;
    end
    if (wr_ok && (addr == wa3)) begin
      return wd3;
    end
    return mem_q[addr];
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
  end

  always_comb begin
    rd2 = read_port(ra2);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          state_d = S_SHOW;
          idx_d   = '0;
        end
      end
      S_SHOW: begin
        if (scan_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + A'(1);
          end
        end
      end
      S_DONE: begin
        // The index only returns to zero here, never by overflow in S_SHOW.
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    scan_valid = (state_q == S_SHOW);
    scan_busy  = (state_q != S_IDLE);
    scan_done  = (state_q == S_DONE);
    scan_addr  = idx_q;
    scan_data  = '0;
    if (state_q == S_SHOW) begin
      scan_data = read_port(idx_q);
    end
  end

endmodule

// File: tb/tb_reg_file_scan.sv
module tb_reg_file_scan;

  logic clk = 1'b0;
  logic rst;

  // 8-bit / 8-entry instance, register 0 hard-wired to zero
  logic       we3, scan_start, scan_ready;
  logic [2:0] wa3, ra1, ra2, scan_addr;
  logic [7:0] wd3, rd1, rd2, scan_data;
  logic       scan_valid, scan_busy, scan_done;

  // 16-bit / 16-entry instance, register 0 ordinary
  logic        we3_w, scan_start_w, scan_ready_w;
  logic [3:0]  wa3_w, ra1_w, ra2_w, scan_addr_w;
  logic [15:0] wd3_w, rd1_w, rd2_w, scan_data_w;
  logic        scan_valid_w, scan_busy_w, scan_done_w;

  reg_file_scan #(.N(8), .A(3), .ZERO_R0(1)) dut8 (
    .clk(clk), .rst(rst),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .scan_start(scan_start), .scan_ready(scan_ready),
    .scan_valid(scan_valid), .scan_addr(scan_addr), .scan_data(scan_data),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  reg_file_scan #(.N(16), .A(4), .ZERO_R0(0)) dut16 (
    .clk(clk), .rst(rst),
    .we3(we3_w), .wa3(wa3_w), .wd3(wd3_w),
    .ra1(ra1_w), .ra2(ra2_w), .rd1(rd1_w), .rd2(rd2_w),
    .scan_start(scan_start_w), .scan_ready(scan_ready_w),
    .scan_valid(scan_valid_w), .scan_addr(scan_addr_w), .scan_data(scan_data_w),
    .scan_busy(scan_busy_w), .scan_done(scan_done_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q8[$];
  exp_t exp_q16[$];
  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  int done_cnt16 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input int a, input int d);
    exp_t e;
    e.addr = 32'(a);
    e.data = 32'(d);
    exp_q8.push_back(e);
  endtask

  task automatic push16(input int a, input int d);
    exp_t e;
    e.addr = 32'(a);
    e.data = 32'(d);
    exp_q16.push_back(e);
  endtask

  task automatic write8(input int a, input int d);
    we3 = 1'b1;
    wa3 = 3'(a);
    wd3 = 8'(d);
    tick();
    we3 = 1'b0;
  endtask

  // Runs from a SHOW cycle until scan_done is seen, counting valid cycles.
  task automatic run_scan(input bit wide, input int budget, output int vcyc, output bit got);
    vcyc = 0;
    got  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (wide ? scan_valid_w : scan_valid) vcyc++;
      if (wide ? scan_done_w : scan_done) got = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_addr8(input int a, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (scan_valid && (scan_addr == 3'(a))) found = 1'b1;
      else tick();
    end
  endtask

  // Monitors: a word is consumed on the edge following a negedge where
  // valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && scan_valid && scan_ready) begin
        if (exp_q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scan8_unexpected: got addr %0d data 0x%0h, none expected", scan_addr, scan_data);
        end else begin
          e = exp_q8.pop_front();
          chk("scan8_addr", 32'(scan_addr), e.addr);
          chk("scan8_data", 32'(scan_data), e.data);
        end
      end
      if (scan_done) done_cnt8++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && scan_valid_w && scan_ready_w) begin
        if (exp_q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scan16_unexpected: got addr %0d data 0x%0h, none expected", scan_addr_w, scan_data_w);
        end else begin
          e = exp_q16.pop_front();
          chk("scan16_addr", 32'(scan_addr_w), e.addr);
          chk("scan16_data", 32'(scan_data_w), e.data);
        end
      end
      if (scan_done_w) done_cnt16++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  vc;
    bit  got;
    bit  found;
    int  d0;

    rst = 1'b0;
    we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    scan_start = 1'b0; scan_ready = 1'b0;
    we3_w = 1'b0; wa3_w = '0; wd3_w = '0; ra1_w = '0; ra2_w = '0;
    scan_start_w = 1'b0; scan_ready_w = 1'b0;

    repeat (2) tick();
    chk("rst_valid", 32'(scan_valid), 32'd0);
    chk("rst_busy",  32'(scan_busy),  32'd0);
    chk("rst_done",  32'(scan_done),  32'd0);
    chk("rst_addr",  32'(scan_addr),  32'd0);
    chk("rst_data",  32'(scan_data),  32'd0);
    chk("rst_rd1",   32'(rd1),        32'd0);
    chk("rst_rd2",   32'(rd2),        32'd0);

    // writes and bypass are both dead while reset is held
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hAA; ra1 = 3'd3;
    #1;
    chk("rst_no_bypass", 32'(rd1), 32'd0);
    tick();
    we3 = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_write_ignored", 32'(rd1), 32'd0);

    // basic write/read and zero register
    write8(3, 8'h5A);
    ra1 = 3'd3;
    #1;
    chk("rd1_r3", 32'(rd1), 32'h5A);
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF; ra2 = 3'd0;
    #1;
    chk("r0_no_bypass", 32'(rd2), 32'h00);
    tick();
    we3 = 1'b0;
    chk("r0_reads_zero", 32'(rd2), 32'h00);

    // same-cycle bypass, other port unaffected
    we3 = 1'b1; wa3 = 3'd5; wd3 = 8'hC3; ra1 = 3'd5; ra2 = 3'd3;
    #1;
    chk("bypass_rd1", 32'(rd1), 32'hC3);
    chk("bypass_rd2_indep", 32'(rd2), 32'h5A);
    tick();
    we3 = 1'b0;
    chk("bypass_committed", 32'(rd1), 32'hC3);

    for (int k = 1; k < 8; k++) write8(k, 8'h10 + k);

    // full scan with ready held high
    for (int k = 0; k < 8; k++) push8(k, (k == 0) ? 0 : 8'h10 + k);
    scan_ready = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("first_word_valid", 32'(scan_valid), 32'd1);
    chk("first_word_addr",  32'(scan_addr),  32'd0);
    run_scan(1'b0, 40, vc, got);
    chk("scan1_done_seen", 32'(got), 32'd1);
    chk("scan1_show_cycles", 32'(vc), 32'd8);
    chk("done_valid_low", 32'(scan_valid), 32'd0);
    chk("done_busy_high", 32'(scan_busy), 32'd1);
    tick();
    chk("idle_busy", 32'(scan_busy), 32'd0);
    chk("idle_done", 32'(scan_done), 32'd0);
    chk("scan1_done_pulses", 32'(done_cnt8), 32'd1);
    chk("scan1_queue_empty", 32'(exp_q8.size()), 32'd0);

    // backpressure at index 4, with writes to a pending and an accepted word
    for (int k = 0; k < 8; k++) push8(k, (k == 0) ? 0 : (k == 6) ? 8'h66 : 8'h10 + k);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_addr8(4, 20, found);
    chk("bp_reach_idx4", 32'(found), 32'd1);
    for (int h = 0; h < 3; h++) begin
      scan_ready = 1'b0;
      we3 = (h < 2);
      wa3 = (h == 0) ? 3'd6 : 3'd2;
      wd3 = (h == 0) ? 8'h66 : 8'h22;
      tick();
      chk("bp_hold_addr", 32'(scan_addr), 32'd4);
      chk("bp_hold_data", 32'(scan_data), 32'h14);
    end
    we3 = 1'b0;
    scan_ready = 1'b1;
    run_scan(1'b0, 40, vc, got);
    chk("scan2_done_seen", 32'(got), 32'd1);
    tick();
    chk("scan2_done_pulses", 32'(done_cnt8), 32'd2);
    chk("scan2_queue_empty", 32'(exp_q8.size()), 32'd0);
    ra1 = 3'd2; ra2 = 3'd6;
    #1;
    chk("accepted_word_rewritten", 32'(rd1), 32'h22);
    chk("pending_word_rewritten",  32'(rd2), 32'h66);

    // reset mid-scan at index 2
    for (int k = 0; k < 8; k++) push8(k, 0);
    exp_q8[1].data = 32'h11;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_addr8(2, 20, found);
    chk("rst_reach_idx2", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    exp_q8.delete();
    chk("abort_valid", 32'(scan_valid), 32'd0);
    chk("abort_busy",  32'(scan_busy),  32'd0);
    chk("abort_addr",  32'(scan_addr),  32'd0);
    chk("abort_data",  32'(scan_data),  32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("abort_no_done", 32'(done_cnt8), 32'd2);
    for (int k = 0; k < 8; k++) begin
      ra1 = 3'(k);
      #1;
      chk("cleared_reg", 32'(rd1), 32'd0);
    end

    // scan_start during SHOW is ignored
    write8(7, 8'h77);
    for (int k = 0; k < 8; k++) push8(k, (k == 7) ? 8'h77 : 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_addr8(3, 20, found);
    chk("restart_reach_idx3", 32'(found), 32'd1);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    run_scan(1'b0, 40, vc, got);
    chk("scan3_done_seen", 32'(got), 32'd1);
    repeat (2) tick();
    chk("scan3_done_pulses", 32'(done_cnt8), 32'd3);
    chk("scan3_queue_empty", 32'(exp_q8.size()), 32'd0);
    chk("start_in_show_ignored", 32'(scan_busy), 32'd0);
    scan_ready = 1'b0;

    // wide instance with ordinary register 0
    we3_w = 1'b1; wa3_w = 4'd0; wd3_w = 16'hBEEF;
    tick();
    wa3_w = 4'd15; wd3_w = 16'h1234;
    tick();
    we3_w = 1'b0;
    ra1_w = 4'd0;
    #1;
    chk("w_r0_ordinary", 32'(rd1_w), 32'hBEEF);
    for (int k = 0; k < 16; k++) begin
      d0 = (k == 0) ? 16'hBEEF : (k == 15) ? 16'h1234 : 0;
      push16(k, d0);
    end
    scan_ready_w = 1'b1;
    scan_start_w = 1'b1;
    tick();
    scan_start_w = 1'b0;
    chk("w_first_addr", 32'(scan_addr_w), 32'd0);
    chk("w_first_data", 32'(scan_data_w), 32'hBEEF);
    run_scan(1'b1, 60, vc, got);
    chk("w_done_seen", 32'(got), 32'd1);
    chk("w_show_cycles", 32'(vc), 32'd16);
    tick();
    chk("w_done_pulses", 32'(done_cnt16), 32'd1);
    chk("w_queue_empty", 32'(exp_q16.size()), 32'd0);
    chk("w_idle", 32'(scan_busy_w), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scan.md
REG_FILE_SCAN -- requirements
Module: reg_file_scan

Interface
REQ-001 Parameter N, default 8: register data width in bits.
REQ-002 Parameter A, default 3: address width; depth D = 2**A registers.
REQ-003 Parameter ZERO_R0, default 1: when 1, register 0 reads 0 and ignores writes; when 0, register 0 is an ordinary register.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 we3  input  1  write enable for write port 3.
REQ-008 wa3  input  A  write address.
REQ-009 wd3  input  N  write data.
REQ-010 ra1  input  A  read address, port 1.
REQ-011 ra2  input  A  read address, port 2.
REQ-012 rd1  output  N  read data, port 1, combinational.
REQ-013 rd2  output  N  read data, port 2, combinational.
REQ-014 scan_start  input  1  request a full-bank scan-out.
REQ-015 scan_ready  input  1  consumer accepts the current scan word.
REQ-016 scan_valid  output  1  scan_addr/scan_data hold a valid word.
REQ-017 scan_addr  output  A  address of the current scan word.
REQ-018 scan_data  output  N  contents of the register at scan_addr.
REQ-019 scan_busy  output  1  high whenever the scan FSM is not IDLE.
REQ-020 scan_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-021 Write: on a rising clk edge with we3=1, reg[wa3] <= wd3; with ZERO_R0=1 and wa3=0, the write is discarded.
REQ-022 Read: rdK = reg[raK] combinationally; with ZERO_R0=1 and raK=0, rdK = 0.
REQ-023 Write-through bypass: if we3=1, raK=wa3, and the write is not discarded, rdK = wd3 in the same cycle.
REQ-024 Both read ports and the scan port are independent; identical addresses on all ports are legal.
REQ-025 Scan FSM states: IDLE, SHOW, DONE.
REQ-026 IDLE: scan_valid=0, scan_busy=0, scan_done=0; scan_start=1 -> SHOW with index=0 on the next edge.
REQ-027 SHOW: scan_valid=1, scan_busy=1, scan_addr=index, scan_data follows REQ-022 and REQ-023 rules at address index.
REQ-028 SHOW transfer occurs on an edge with scan_valid=1 and scan_ready=1; index=D-1 -> DONE, otherwise index <= index+1.
REQ-029 SHOW without scan_ready: state, index, scan_addr and scan_data (absent writes) are held unchanged.
REQ-030 DONE: scan_done=1, scan_busy=1, scan_valid=0 for exactly one cycle, then -> IDLE unconditionally.
REQ-031 scan_start is ignored in SHOW and DONE; a new scan requires IDLE.
REQ-032 Writes proceed normally during a scan; a word not yet shown reflects the write; an already-accepted word does not.
REQ-033 Transfer latency: the first word is valid 1 cycle after scan_start; a full scan with scan_ready held high takes D cycles in SHOW plus 1 in DONE.
REQ-034 index wraps only through DONE; no index wrap-around occurs inside SHOW.

Reset
REQ-035 rst=0 asynchronously clears every register to 0, forces the FSM to IDLE, and sets index to 0.
REQ-036 During and after reset until the next event: scan_valid=0, scan_busy=0, scan_done=0, scan_addr=0, scan_data=0, rd1=rd2=0.
REQ-037 Reset asserted mid-scan aborts the scan with no scan_done pulse.
REQ-038 Writes are ignored while rst=0.

Verification
REQ-039 Defaults: write 0x5A to r3, ra1=3 -> rd1=0x5A; write 0xFF to r0, ra2=0 -> rd2=0x00.
REQ-040 Bypass: we3=1, wa3=5, wd3=0xC3, ra1=5 in the same cycle -> rd1=0xC3 before the edge.
REQ-041 Scan: load rK=0x10+K for K=1..7, assert scan_start, hold scan_ready=1 -> 8 words (00,11,...,17), addresses 0..7, then one scan_done pulse.
REQ-042 Backpressure: drop scan_ready for 3 cycles at index 4 -> scan_addr=4 and scan_data=0x14 are held, and the scan resumes with no loss or duplication.
REQ-043 Reset at index 2 -> immediate IDLE, all registers read 0, no scan_done pulse; scan_start during SHOW -> ignored.
REQ-044 ZERO_R0=0, N=16, A=4: write 0xBEEF to r0 and scan -> 16 words, with word 0 equal to 0xBEEF.
